// File: rtl/pwl_activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pwl_activation_pipe
// Purpose  : Three-stage piecewise-linear sigmoid/tanh evaluator with a
//            runtime-writable, two-bank slope/intercept table and a
//            valid/ready streaming interface (one sample per clock).
// Ports    : clk, rst               - clock, synchronous active-high reset
//            in_valid/in_ready      - input handshake
//            in_data, in_mode       - signed sample x, 0=sigmoid 1=tanh
//            out_valid/out_ready    - output handshake
//            out_data               - signed result z
//            cfg_we/bank/sel/addr/data - coefficient table write port
// Revision : 1.0 - initial release
// ============================================================================
module pwl_activation_pipe #(
  parameter int BITS      = 16,
  parameter int FRAC      = 8,
  parameter int SEGS      = 13,
  parameter int SEG_SHIFT = 7,
  parameter int AW        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  input  logic            cfg_we,
  input  logic            cfg_bank,
  input  logic            cfg_sel,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [BITS-1:0] cfg_data
);

  localparam logic [BITS-1:0] C_MAXPOS = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] C_MINNEG = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS:0]   C_ONE    = (BITS+1)'(1) << FRAC;
  localparam logic [BITS-1:0] C_ONE_W  = BITS'(1) << FRAC;
  localparam logic [AW-1:0]   C_LAST   = AW'(SEGS - 1);
  localparam logic [BITS-1:0] C_LAST_W = BITS'(SEGS - 1);
  localparam logic [AW:0]     C_SEGS   = (AW+1)'(SEGS);

  // Coefficient table: not reset, loaded by software before use.
  logic [BITS-1:0] slope_q [2][2**AW];
  logic [BITS-1:0] icpt_q  [2][2**AW];

  // Pipeline state
  logic            v1_q, v2_q, out_valid_q;
  logic [BITS-1:0] xa1_q, m1_q, c1_q;
  logic            neg1_q, mode1_q;
  logic [BITS-1:0] mx2_q, c2_q;
  logic            neg2_q, mode2_q;
  logic [BITS-1:0] out_data_q;

  logic            en;
  logic            neg_d;
  logic [BITS-1:0] xa_d, seg_d;
  logic [AW-1:0]   idx_d;
  logic [2*BITS-1:0] prod_d, mx_full_d;
  logic [BITS-1:0] mx_d;
  logic [BITS:0]   y_d;
  logic [BITS-1:0] yc_d, z_d;

  // Single global stall: every stage advances only when the output slot
  // is empty or being drained.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Table writes ignore the stall. Non-blocking update means a lookup in
  // the same cycle as a write to the same entry still sees the old value.
  always_ff @(posedge clk) begin
    if (cfg_we && ({1'b0, cfg_addr} < C_SEGS)) begin
      if (cfg_sel) icpt_q[cfg_bank][cfg_addr]  <= cfg_data;
      else         slope_q[cfg_bank][cfg_addr] <= cfg_data;
    end
  end

  // S1: magnitude and segment index. The most-negative input has no
  // positive counterpart, so its magnitude saturates.
  always_comb begin
    neg_d = in_data[BITS-1];
    if (in_data == C_MINNEG) xa_d = C_MAXPOS;
    else if (neg_d)          xa_d = -in_data;
    else                     xa_d = in_data;
    seg_d = xa_d >> SEG_SHIFT;
    idx_d = (seg_d >= C_LAST_W) ? C_LAST : seg_d[AW-1:0];
  end

  // S2: unsigned magnitude * slope, rescaled and saturated.
  always_comb begin
    prod_d    = {{BITS{1'b0}}, xa1_q} * {{BITS{1'b0}}, m1_q};
    mx_full_d = prod_d >> FRAC;
    mx_d      = (mx_full_d > {{BITS{1'b0}}, C_MAXPOS}) ? C_MAXPOS : mx_full_d[BITS-1:0];
  end

  // S3: add intercept, clamp to [0, ONE], then apply the odd/point
  // symmetry of the selected function for negative inputs.
  always_comb begin
    y_d  = {1'b0, mx2_q} + {1'b0, c2_q};
    yc_d = (y_d > C_ONE) ? C_ONE_W : y_d[BITS-1:0];
    if (mode2_q) z_d = neg2_q ? -yc_d : yc_d;
    else         z_d = neg2_q ? (C_ONE_W - yc_d) : yc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      v1_q        <= in_valid;
      xa1_q       <= xa_d;
      neg1_q      <= neg_d;
      mode1_q     <= in_mode;
      m1_q        <= slope_q[in_mode][idx_d];
      c1_q        <= icpt_q[in_mode][idx_d];

      v2_q        <= v1_q;
      mx2_q       <= mx_d;
      c2_q        <= c1_q;
      neg2_q      <= neg1_q;
      mode2_q     <= mode1_q;

      out_valid_q <= v2_q;
      if (v2_q) out_data_q <= z_d;
    end
  end

endmodule
`default_nettype wire
